// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, jump/branch flush, interrupt entry/exit
// with EPC capture, and saturating stall/flush event counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_Valid,
    input  logic [31:0]      ID_PC_4,
    input  logic             ID_Jump,
    input  logic             ID_Eret,
    input  logic             EX_MemRd,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_BranchTaken,
    input  logic             IRQ,
    output logic             PC_Hold,
    output logic [1:0]       PC_Src,
    output logic             IF_ID_Stall,
    output logic             IF_ID_Hold,
    output logic             ID_EX_Stall,
    output logic [31:0]      EPC,
    output logic             InKernel,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // state | meaning
    // RUN   | normal execution, interrupts may be taken
    // KERNEL| handler running, interrupts masked until eret
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_KERNEL = 1'b1;

    localparam logic [1:0] SRC_PC4    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_VECTOR = 2'b11;

    logic [0:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic             irq_d_q, irq_d_d;
    logic             armed_q, armed_d;
    logic [31:0]      epc_q, epc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic take_req;
    logic irq_rise;
    logic sel_branch, sel_lu, sel_jump, sel_take;

    always_comb begin
        load_use = EX_MemRd & (EX_Rt != 5'd0) &
                   ((ID_UsesRs & (ID_Rs == EX_Rt)) | (ID_UsesRt & (ID_Rt == EX_Rt)));
        take_req = pending_q & (state_q == ST_RUN) & ID_Valid & ~ID_Eret;
        // armed_q masks the first clock after reset so a held-high IRQ is not an edge
        irq_rise = IRQ & ~irq_d_q & armed_q;

        // gating with reset forces every control output low while reset is asserted
        sel_branch = reset & EX_BranchTaken;
        sel_lu     = reset & ~EX_BranchTaken & load_use;
        sel_jump   = reset & ~EX_BranchTaken & ~load_use & ID_Jump;
        sel_take   = reset & ~EX_BranchTaken & ~load_use & ~ID_Jump & take_req;
    end

    always_comb begin
        PC_Src = SRC_PC4;
        if (sel_branch) begin
            PC_Src = SRC_BRANCH;
        end else if (sel_jump) begin
            PC_Src = SRC_JUMP;
        end else if (sel_take) begin
            PC_Src = SRC_VECTOR;
        end
        PC_Hold     = sel_lu;
        IF_ID_Hold  = sel_lu;
        IF_ID_Stall = sel_branch | sel_jump | sel_take;
        ID_EX_Stall = sel_branch | sel_lu | sel_take;
    end

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        irq_d_d   = IRQ;
        armed_d   = 1'b1;
        pending_d = (pending_q & ~sel_take) | irq_rise;

        if (sel_take) begin
            state_d = ST_KERNEL;
            epc_d   = ID_PC_4 - 32'd4;
        end else if ((state_q == ST_KERNEL) & ID_Eret & ID_Valid &
                     ~EX_BranchTaken & ~load_use) begin
            state_d = ST_RUN;
        end

        stall_cnt_d = stall_cnt_q;
        if (sel_lu && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (IF_ID_Stall && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pending_q   <= 1'b0;
            irq_d_q     <= 1'b0;
            armed_q     <= 1'b0;
            epc_q       <= 32'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            irq_d_q     <= irq_d_d;
            armed_q     <= armed_d;
            epc_q       <= epc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign EPC      = epc_q;
    assign InKernel = (state_q == ST_KERNEL);
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: priority vector table, directed interrupt/reset/saturation
// sequences, and randomized traffic against a behavioural model.
module tb_hazard_unit;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_Rs, ID_Rt, EX_Rt;
    logic             ID_UsesRs, ID_UsesRt, ID_Valid, ID_Jump, ID_Eret;
    logic [31:0]      ID_PC_4;
    logic             EX_MemRd, EX_BranchTaken, IRQ;
    logic             PC_Hold, IF_ID_Stall, IF_ID_Hold, ID_EX_Stall, InKernel;
    logic [1:0]       PC_Src;
    logic [31:0]      EPC;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int checks = 0;
    int failures = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_Valid(ID_Valid), .ID_PC_4(ID_PC_4), .ID_Jump(ID_Jump), .ID_Eret(ID_Eret),
        .EX_MemRd(EX_MemRd), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken), .IRQ(IRQ),
        .PC_Hold(PC_Hold), .PC_Src(PC_Src), .IF_ID_Stall(IF_ID_Stall),
        .IF_ID_Hold(IF_ID_Hold), .ID_EX_Stall(ID_EX_Stall), .EPC(EPC),
        .InKernel(InKernel), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: spec rules evaluated directly each cycle.
    bit               m_pending, m_kernel, m_irq_prev, m_first;
    logic [31:0]      m_epc;
    int               m_stall, m_flush;
    int               e_win;  // 0 none, 1 load-use, 2 branch, 3 take, 4 jump
    bit               e_lu;
    logic             e_hold, e_ifs, e_ifh, e_exs;
    logic [1:0]       e_src;

    task automatic model_reset();
        m_pending = 0; m_kernel = 0; m_irq_prev = 0; m_first = 1;
        m_epc = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_comb();
        e_lu = EX_MemRd && (EX_Rt != 0) &&
               ((ID_UsesRs && ID_Rs == EX_Rt) || (ID_UsesRt && ID_Rt == EX_Rt));
        e_win = 0;
        if (!reset)              e_win = 0;
        else if (EX_BranchTaken) e_win = 2;
        else if (e_lu)           e_win = 1;
        else if (ID_Jump)        e_win = 4;
        else if (m_pending && !m_kernel && ID_Valid && !ID_Eret) e_win = 3;
        e_hold = (e_win == 1);
        e_ifh  = (e_win == 1);
        e_ifs  = (e_win == 2) || (e_win == 3) || (e_win == 4);
        e_exs  = (e_win == 1) || (e_win == 2) || (e_win == 3);
        case (e_win)
            2: e_src = 2'b01;
            4: e_src = 2'b10;
            3: e_src = 2'b11;
            default: e_src = 2'b00;
        endcase
    endtask

    task automatic model_step();
        bit rise;
        if (!reset) begin
            model_reset();
            return;
        end
        rise = IRQ && !m_irq_prev && !m_first;
        if (e_win == 3) begin
            m_kernel = 1; m_epc = ID_PC_4 - 32'd4; m_pending = 0;
        end else if (m_kernel && ID_Eret && ID_Valid && !EX_BranchTaken && !e_lu) begin
            m_kernel = 0;
        end
        if (rise) m_pending = 1;
        if (e_win == 1 && m_stall < 65535) m_stall++;
        if (e_ifs && m_flush < 65535) m_flush++;
        m_irq_prev = IRQ;
        m_first = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic settle(input bit check_all);
        @(negedge clk);
        model_comb();
        if (check_all) begin
            chk("pc_hold", 32'(PC_Hold), 32'(e_hold));
            chk("pc_src", 32'(PC_Src), 32'(e_src));
            chk("if_id_stall", 32'(IF_ID_Stall), 32'(e_ifs));
            chk("if_id_hold", 32'(IF_ID_Hold), 32'(e_ifh));
            chk("id_ex_stall", 32'(ID_EX_Stall), 32'(e_exs));
            chk("in_kernel", 32'(InKernel), 32'(m_kernel));
            chk("epc", EPC, m_epc);
            chk("stall_cnt", 32'(StallCnt), 32'(m_stall));
            chk("flush_cnt", 32'(FlushCnt), 32'(m_flush));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        ID_Rs = 0; ID_Rt = 0; EX_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
        ID_Valid = 0; ID_Jump = 0; ID_Eret = 0; ID_PC_4 = 0;
        EX_MemRd = 0; EX_BranchTaken = 0; IRQ = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        settle(1);
        advance();
        settle(1);
        advance();
        reset = 1;
    endtask

    typedef struct {
        logic       br, memrd;
        logic [4:0] ex_rt, rs, rt;
        logic       urs, urt, jump;
        logic       hold;
        logic [1:0] src;
        logic       ifs, ifh, exs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

        clear_inputs();
        do_reset();

        // Priority table, RUN state, nothing pending.
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            EX_BranchTaken = vecs[i].br; EX_MemRd = vecs[i].memrd; EX_Rt = vecs[i].ex_rt;
            ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; ID_UsesRs = vecs[i].urs;
            ID_UsesRt = vecs[i].urt; ID_Jump = vecs[i].jump;
            settle(1);
            chk($sformatf("vec%0d_pc_hold", i), 32'(PC_Hold), 32'(vecs[i].hold));
            chk($sformatf("vec%0d_pc_src", i), 32'(PC_Src), 32'(vecs[i].src));
            chk($sformatf("vec%0d_if_id_stall", i), 32'(IF_ID_Stall), 32'(vecs[i].ifs));
            chk($sformatf("vec%0d_if_id_hold", i), 32'(IF_ID_Hold), 32'(vecs[i].ifh));
            chk($sformatf("vec%0d_id_ex_stall", i), 32'(ID_EX_Stall), 32'(vecs[i].exs));
            advance();
        end
        clear_inputs();
        settle(1);
        chk("table_stall_cnt", 32'(StallCnt), 32'd3);
        chk("table_flush_cnt", 32'(FlushCnt), 32'd2);
        advance();

        // Interrupt entry, masked edge in kernel, eret, deferred take.
        ID_Valid = 1; ID_PC_4 = 32'h0040_0014; IRQ = 1;
        settle(1);
        chk("irq_edge_cycle_src", 32'(PC_Src), 32'd0);
        advance();
        settle(1);
        chk("take_src", 32'(PC_Src), 32'd3);
        chk("take_if_id_stall", 32'(IF_ID_Stall), 32'd1);
        chk("take_id_ex_stall", 32'(ID_EX_Stall), 32'd1);
        advance();
        settle(1);
        chk("entry_in_kernel", 32'(InKernel), 32'd1);
        chk("entry_epc", EPC, 32'h0040_0010);
        chk("entry_src_idle", 32'(PC_Src), 32'd0);
        IRQ = 0;
        advance();
        IRQ = 1;
        settle(1);
        advance();
        settle(1);
        chk("kernel_no_take", 32'(PC_Src), 32'd0);
        advance();
        ID_Eret = 1;
        settle(1);
        chk("eret_src", 32'(PC_Src), 32'd0);
        advance();
        ID_Eret = 0;
        settle(1);
        chk("after_eret_kernel", 32'(InKernel), 32'd0);
        chk("after_eret_take", 32'(PC_Src), 32'd3);
        advance();
        settle(1);
        chk("reentry_kernel", 32'(InKernel), 32'd1);
        advance();

        // IRQ held high through reset release must not look like an edge.
        clear_inputs();
        IRQ = 1;
        do_reset();
        ID_Valid = 1; ID_PC_4 = 32'h100;
        for (int i = 0; i < 3; i++) begin
            settle(1);
            chk("held_irq_no_take", 32'(PC_Src), 32'd0);
            advance();
        end

        // Randomized traffic.
        clear_inputs();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (reset == 0) begin
                reset = 1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                model_reset();
            end
            ID_Rs = 5'($urandom_range(0, 3));
            ID_Rt = 5'($urandom_range(0, 3));
            EX_Rt = 5'($urandom_range(0, 3));
            ID_UsesRs = 1'($urandom_range(0, 1));
            ID_UsesRt = 1'($urandom_range(0, 1));
            EX_MemRd = ($urandom_range(0, 2) == 0);
            ID_Valid = ($urandom_range(0, 3) != 0);
            ID_Jump = ($urandom_range(0, 7) == 0);
            ID_Eret = ($urandom_range(0, 7) == 0);
            EX_BranchTaken = ($urandom_range(0, 7) == 0);
            ID_PC_4 = $urandom;
            if ($urandom_range(0, 5) == 0) IRQ = ~IRQ;
            settle(1);
            advance();
        end
        reset = 1;

        // Counter saturation, then reset asserted mid-sequence.
        clear_inputs();
        do_reset();
        EX_MemRd = 1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1;
        for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
            settle(0);
            advance();
        end
        settle(1);
        chk("stall_cnt_saturated", 32'(StallCnt), 32'(CMAX));
        chk("sat_pc_hold", 32'(PC_Hold), 32'd1);
        advance();
        reset = 0;
        model_reset();
        #1;
        chk("rst_stall_cnt", 32'(StallCnt), 32'd0);
        chk("rst_flush_cnt", 32'(FlushCnt), 32'd0);
        chk("rst_pc_hold", 32'(PC_Hold), 32'd0);
        chk("rst_id_ex_stall", 32'(ID_EX_Stall), 32'd0);
        EX_BranchTaken = 1;
        settle(1);
        chk("rst_branch_src", 32'(PC_Src), 32'd0);
        advance();
        reset = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
